draw_scheduler: RTL and testbench

- Controller in front of the board/score pixel drawer.
- Watches the 3x3 board word and the three decoded score words, and marks changed items dirty.
- Issues one draw command at a time to the drawer over a valid/ready + done handshake.
- Order of issue: screen clear first, then dirty cells in index order, then dirty scores. Only changed items are redrawn, so the drawer is never swept blindly.

---
 rtl/draw_scheduler_pkg.sv | 33 +++
 rtl/draw_scheduler_pick.sv | 41 ++++
 rtl/draw_scheduler.sv | 167 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_scheduler_pkg.sv
`default_nettype none
// =============================================================================
// draw_scheduler_pkg : command encodings, FSM states and cell-slice helper
// Revision: 1.0
// =============================================================================
package draw_scheduler_pkg;

  localparam int NUM_CELLS  = 9;
  localparam int NUM_SCORES = 3;

  localparam logic [1:0] KIND_CELL  = 2'd0;
  localparam logic [1:0] KIND_SCORE = 2'd1;
  localparam logic [1:0] KIND_CLEAR = 2'd2;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Cell k sits at bits [17-2k:16-2k], so cell 0 is the most significant pair.
  function automatic logic [1:0] cell_of(input logic [17:0] g, input logic [3:0] k);
    logic [4:0] lo;
    lo = 5'd16 - {k, 1'b0};
    return g[lo +: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_scheduler_pick.sv
`default_nettype none
// =============================================================================
// draw_pick : fixed-priority selector clear > lowest cell > lowest score
// Revision: 1.0
// =============================================================================
module draw_pick
  import draw_scheduler_pkg::*;
(
  input  logic                  pending_clear_i,
  input  logic [NUM_CELLS-1:0]  cell_dirty_i,
  input  logic [NUM_SCORES-1:0] score_dirty_i,
  output logic                  found_o,
  output logic [1:0]            kind_o,
  output logic [3:0]            index_o
);

  always_comb begin
    found_o = 1'b0;
    kind_o  = KIND_CELL;
    index_o = 4'd0;
    if (pending_clear_i) begin
      found_o = 1'b1;
      kind_o  = KIND_CLEAR;
    end else if (|cell_dirty_i) begin
      found_o = 1'b1;
      kind_o  = KIND_CELL;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
        if (cell_dirty_i[i]) index_o = 4'(i);
      end
    end else if (|score_dirty_i) begin
      found_o = 1'b1;
      kind_o  = KIND_SCORE;
      for (int i = NUM_SCORES - 1; i >= 0; i--) begin
        if (score_dirty_i[i]) index_o = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// =============================================================================
// draw_scheduler : tracks dirty board cells/scores and issues draw commands
// Revision: 1.0
// =============================================================================
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int TMO_W   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] grid,
  input  logic [14:0] p1_decoded,
  input  logic [14:0] p2_decoded,
  input  logic [14:0] tie_decoded,
  input  logic        clear_req,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_kind,
  output logic [3:0]  cmd_index,
  output logic [1:0]  cmd_value,
  input  logic        draw_done,
  output logic        busy,
  output logic        err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [17:0]            grid_sh_q;
  logic [14:0]            p1_sh_q, p2_sh_q, tie_sh_q;
  logic                   pend_clear_q, pend_clear_d;
  logic [NUM_CELLS-1:0]   cell_dirty_q, cell_dirty_d;
  logic [NUM_SCORES-1:0]  score_dirty_q, score_dirty_d;
  logic [1:0]             kind_q, kind_d;
  logic [3:0]             index_q, index_d;
  logic [1:0]             value_q, value_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   err_q, err_d;

  logic [NUM_CELLS-1:0]   cell_chg;
  logic [NUM_SCORES-1:0]  score_chg;
  logic                   pc_set, pc_clr;
  logic [NUM_CELLS-1:0]   cd_set, cd_clr;
  logic [NUM_SCORES-1:0]  sd_set, sd_clr;
  logic                   pick_found;
  logic [1:0]             pick_kind;
  logic [3:0]             pick_index;

  generate
    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell_cmp
      assign cell_chg[k] = cell_of(grid, 4'(k)) != cell_of(grid_sh_q, 4'(k));
    end
  endgenerate

  assign score_chg = {tie_decoded != tie_sh_q, p2_decoded != p2_sh_q, p1_decoded != p1_sh_q};

  draw_pick u_pick (
    .pending_clear_i (pend_clear_q),
    .cell_dirty_i    (cell_dirty_q),
    .score_dirty_i   (score_dirty_q),
    .found_o         (pick_found),
    .kind_o          (pick_kind),
    .index_o         (pick_index)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    index_d = index_q;
    value_d = value_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pc_set  = clear_req;
    pc_clr  = 1'b0;
    cd_set  = cell_chg | {NUM_CELLS{clear_req}};
    cd_clr  = '0;
    sd_set  = score_chg | {NUM_SCORES{clear_req}};
    sd_clr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          kind_d  = pick_kind;
          index_d = pick_index;
          value_d = (pick_kind == KIND_CELL) ? cell_of(grid, pick_index) : CELL_EMPTY;
          if (pick_kind == KIND_CLEAR) pc_clr = 1'b1;
          else if (pick_kind == KIND_CELL)
            cd_clr = {{(NUM_CELLS-1){1'b0}}, 1'b1} << pick_index;
          else
            sd_clr = {{(NUM_SCORES-1){1'b0}}, 1'b1} << pick_index;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (draw_done) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: re-arm the same item so it is retried from IDLE.
          err_d   = 1'b1;
          state_d = ST_IDLE;
          if (kind_q == KIND_CLEAR) pc_set = 1'b1;
          else if (kind_q == KIND_CELL)
            cd_set = cd_set | ({{(NUM_CELLS-1){1'b0}}, 1'b1} << index_q);
          else
            sd_set = sd_set | ({{(NUM_SCORES-1){1'b0}}, 1'b1} << index_q);
        end else if (tmo_q != {TMO_W{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_clear_d  = (pend_clear_q & ~pc_clr) | pc_set;
    cell_dirty_d  = (cell_dirty_q & ~cd_clr) | cd_set;
    score_dirty_d = (score_dirty_q & ~sd_clr) | sd_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grid_sh_q     <= '0;
      p1_sh_q       <= '0;
      p2_sh_q       <= '0;
      tie_sh_q      <= '0;
      pend_clear_q  <= 1'b1;
      cell_dirty_q  <= {NUM_CELLS{1'b1}};
      score_dirty_q <= {NUM_SCORES{1'b1}};
      kind_q        <= 2'd0;
      index_q       <= 4'd0;
      value_q       <= 2'd0;
      tmo_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grid_sh_q     <= grid;
      p1_sh_q       <= p1_decoded;
      p2_sh_q       <= p2_decoded;
      tie_sh_q      <= tie_decoded;
      pend_clear_q  <= pend_clear_d;
      cell_dirty_q  <= cell_dirty_d;
      score_dirty_q <= score_dirty_d;
      kind_q        <= kind_d;
      index_q       <= index_d;
      value_q       <= value_d;
      tmo_q         <= tmo_d;
      err_q         <= err_d;
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign cmd_kind  = kind_q;
  assign cmd_index = index_q;
  assign cmd_value = value_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE) | pend_clear_q | (|cell_dirty_q) | (|score_dirty_q);

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// =============================================================================
// tb_draw_scheduler : randomized drawer model and expected command sequences
// Revision: 1.0
// =============================================================================
module tb_draw_scheduler;

  typedef logic [7:0] cmdq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] grid = '0;
  logic [14:0] p1_decoded = '0, p2_decoded = '0, tie_decoded = '0;
  logic        clear_req = 1'b0, cmd_ready = 1'b0, draw_done = 1'b0;
  logic        cmd_valid, busy, err;
  logic [1:0]  cmd_kind, cmd_value;
  logic [3:0]  cmd_index;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int rdy_wait = 0, done_wait = 5, ph = 0, dcnt = 0, acc_cyc = 0;
  bit withhold = 1'b0;
  logic [7:0] got[$];

  draw_scheduler #(.TIMEOUT(16), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .grid(grid), .p1_decoded(p1_decoded),
    .p2_decoded(p2_decoded), .tie_decoded(tie_decoded), .clear_req(clear_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_index(cmd_index), .cmd_value(cmd_value), .draw_done(draw_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mk(input int k, input int i, input int v);
    return {2'(k), 4'(i), 2'(v)};
  endfunction

  function automatic int cellv(input logic [17:0] g, input int k);
    return int'((g >> (16 - 2 * k)) & 18'h3);
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] g, input int k, input int v);
    logic [17:0] m;
    m = 18'h3 << (16 - 2 * k);
    return (g & ~m) | ((18'(v) & 18'h3) << (16 - 2 * k));
  endfunction

  function automatic cmdq_t full_redraw(input logic [17:0] g);
    cmdq_t q;
    q.push_back(mk(2, 0, 0));
    for (int k = 0; k < 9; k++) q.push_back(mk(0, k, cellv(g, k)));
    for (int s = 0; s < 3; s++) q.push_back(mk(1, s, 0));
    return q;
  endfunction

  // Drawer model: ready after rdy_wait cycles of valid, done done_wait cycles after accept.
  initial begin
    forever begin
      @(negedge clk);
      draw_done = 1'b0;
      cmd_ready = 1'b0;
      if (reset) begin
        ph = 0; dcnt = 0;
      end else begin
        if (ph == 1 && cmd_valid) begin ph = 0; dcnt = 0; end
        if (ph == 2) begin
          ph = 0; dcnt = 0;
        end else if (ph == 0) begin
          if (cmd_valid) begin
            if (dcnt >= rdy_wait) begin
              cmd_ready = 1'b1;
              got.push_back({cmd_kind, cmd_index, cmd_value});
              acc_cyc = cyc;
              ph = 1; dcnt = 0;
            end else dcnt++;
          end else dcnt = 0;
        end else begin
          dcnt++;
          if (!withhold && dcnt == done_wait) begin draw_done = 1'b1; ph = 2; end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || cmd_valid || ph != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle", 32'(busy | cmd_valid | (ph != 0)), 0);
  endtask

  task automatic wait_cmds(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("cmd_seen", 32'(got.size() >= n), 1);
  endtask

  task automatic cmp_cmds(input cmdq_t e);
    check("ncmd", 32'(got.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got.size(); i++)
      check($sformatf("cmd%0d", i), 32'(got[i]), 32'(e[i]));
    got.delete();
  endtask

  initial begin
    cmdq_t e;
    logic [17:0] ng;
    logic [14:0] n1, n2, nt;
    logic [7:0] lat;
    int v1, v2, v7, c, err_cyc;

    for (int k = 0; k < 9; k++) grid = set_cell(grid, k, $urandom_range(0, 3));
    p1_decoded = 15'($urandom); p2_decoded = 15'($urandom); tie_decoded = 15'($urandom);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'({cmd_valid, cmd_kind, cmd_index, cmd_value}), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 1);
    reset = 1'b0;
    wait_idle(500);
    cmp_cmds(full_redraw(grid));
    check("post_busy", 32'(busy), 0);
    check("post_err", 32'(err), 0);

    // Single cell change from an empty board.
    grid = '0;
    wait_idle(500);
    got.delete();
    grid = 18'h10000;
    wait_idle(200);
    e = {mk(0, 0, 1)};
    cmp_cmds(e);

    // Random batches of cell/score changes applied from idle.
    for (int it = 0; it < 10; it++) begin
      rdy_wait  = $urandom_range(0, 3);
      done_wait = $urandom_range(1, 6);
      ng = grid;
      for (int k = 0; k < 9; k++)
        if ($urandom_range(0, 2) == 0) ng = set_cell(ng, k, $urandom_range(0, 3));
      n1 = ($urandom_range(0, 2) == 0) ? p1_decoded ^ 15'($urandom_range(1, 32767)) : p1_decoded;
      n2 = ($urandom_range(0, 2) == 0) ? p2_decoded ^ 15'($urandom_range(1, 32767)) : p2_decoded;
      nt = ($urandom_range(0, 2) == 0) ? tie_decoded ^ 15'($urandom_range(1, 32767)) : tie_decoded;
      e.delete();
      for (int k = 0; k < 9; k++)
        if (cellv(ng, k) != cellv(grid, k)) e.push_back(mk(0, k, cellv(ng, k)));
      if (n1 != p1_decoded) e.push_back(mk(1, 0, 0));
      if (n2 != p2_decoded) e.push_back(mk(1, 1, 0));
      if (nt != tie_decoded) e.push_back(mk(1, 2, 0));
      grid = ng; p1_decoded = n1; p2_decoded = n2; tie_decoded = nt;
      wait_idle(800);
      cmp_cmds(e);
    end

    // Cells 3 and 7 change while cell 3 is being drawn.
    rdy_wait = 0; done_wait = 8;
    v1 = (cellv(grid, 3) + 1) % 4;
    grid = set_cell(grid, 3, v1);
    wait_cmds(1, 50);
    v2 = (v1 + 1) % 4;
    v7 = (cellv(grid, 7) + 1) % 4;
    grid = set_cell(set_cell(grid, 3, v2), 7, v7);
    wait_idle(200);
    e = {mk(0, 3, v1), mk(0, 3, v2), mk(0, 7, v7)};
    cmp_cmds(e);

    // Back-pressure: ready withheld for 10 cycles.
    rdy_wait = 10; done_wait = 3;
    v1 = (cellv(grid, 5) + 1) % 4;
    grid = set_cell(grid, 5, v1);
    c = 0;
    while (!cmd_valid && c < 20) begin @(negedge clk); c++; end
    check("bp_valid", 32'(cmd_valid), 1);
    lat = {cmd_kind, cmd_index, cmd_value};
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", 32'({cmd_valid, cmd_kind, cmd_index, cmd_value}), 32'({1'b1, lat}));
    end
    wait_idle(200);
    e = {mk(0, 5, v1)};
    cmp_cmds(e);
    rdy_wait = 0;

    // Withheld done triggers timeout, err and a reissue of the same cell.
    check("pre_tmo_err", 32'(err), 0);
    withhold = 1'b1;
    v1 = (cellv(grid, 8) + 1) % 4;
    grid = set_cell(grid, 8, v1);
    wait_cmds(1, 50);
    c = 0;
    while (!err && c < 100) begin @(negedge clk); c++; end
    err_cyc = cyc;
    withhold = 1'b0;
    check("tmo_err", 32'(err), 1);
    check("tmo_lat", 32'(err_cyc - acc_cyc - 1), 16);
    wait_idle(200);
    e = {mk(0, 8, v1), mk(0, 8, v1)};
    cmp_cmds(e);
    check("err_sticky", 32'(err), 1);
    v1 = (cellv(grid, 0) + 1) % 4;
    grid = set_cell(grid, 0, v1);
    wait_idle(200);
    e = {mk(0, 0, v1)};
    cmp_cmds(e);
    check("err_sticky2", 32'(err), 1);

    // clear_req plus a p2 change during a score command.
    done_wait = 6;
    p1_decoded = p1_decoded ^ 15'h1;
    wait_cmds(1, 50);
    repeat (2) @(negedge clk);
    clear_req = 1'b1;
    p2_decoded = p2_decoded ^ 15'h55;
    @(negedge clk);
    clear_req = 1'b0;
    wait_idle(800);
    e = full_redraw(grid);
    e.push_front(mk(1, 0, 0));
    cmp_cmds(e);

    // Reset while a command is offered.
    rdy_wait = 20;
    grid = set_cell(grid, 1, (cellv(grid, 1) + 1) % 4);
    c = 0;
    while (!cmd_valid && c < 20) begin @(negedge clk); c++; end
    check("mid_valid", 32'(cmd_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", 32'({cmd_valid, cmd_kind, cmd_index, cmd_value}), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_busy", 32'(busy), 1);
    check("mid_noacc", 32'(got.size()), 0);
    reset = 1'b0;
    rdy_wait = 0;
    wait_idle(800);
    cmp_cmds(full_redraw(grid));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
